// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the if_prefetch instruction-fetch front end.
package if_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } st_t;

  localparam logic [1:0] RESP_IF  = 2'b01;
  localparam logic [1:0] RESP_MEM = 2'b10;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_prefetch_fifo.sv
// if_fifo: DEPTH-entry FIFO with synchronous clear; head reads as zero when empty.
module if_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly PW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && do_push) mem[wr_ptr] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Prefetching instruction-fetch stage: one outstanding fetch, DEPTH-entry queue.
// Optional IF_PREFETCH_STAT_EN adds saturating fetch/flush counters.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              if_request,
  output logic [ADDR_W-1:0] if_addr,
  input  logic              busy_mem_ctrl,
  input  logic [1:0]        if_or_mem_i,
  input  logic [INST_W-1:0] mcl_instr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready
`ifdef IF_PREFETCH_STAT_EN
  ,
  output logic [31:0]       stat_fetch_cnt,
  output logic [31:0]       stat_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  st_t               st;
  st_t               st_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic              resp_if;
  logic              push;
  logic              pop;
  logic              clr;
  logic              q_empty;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;

  assign resp_if = (if_or_mem_i == RESP_IF);

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   ({fetch_pc, mcl_instr}),
    .head  (head),
    .count (count),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      st       <= st_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Redirect overrides everything: clear queue, suppress pop/push and new requests.
  always_comb begin
    st_nxt       = st;
    fetch_pc_nxt = fetch_pc;
    if_request   = 1'b0;
    if_addr      = '0;
    push         = 1'b0;
    clr          = 1'b0;
    pop          = !q_empty && id_ready && !jump_en;
    if (jump_en) begin
      clr          = 1'b1;
      fetch_pc_nxt = jump_addr;
      if (st == WAIT) st_nxt = resp_if ? IDLE : DRAIN;
    end else begin
      unique case (st)
        IDLE: begin
          if (!busy_mem_ctrl && (count < CNT_W'(DEPTH))) begin
            if_request = 1'b1;
            if_addr    = fetch_pc;
            st_nxt     = WAIT;
          end
        end
        WAIT: begin
          if (resp_if) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + ADDR_W'(PC_INC);
            st_nxt       = IDLE;
          end
        end
        DRAIN: begin
          if (resp_if) st_nxt = IDLE;
        end
        default: st_nxt = IDLE;
      endcase
    end
    if (rst) begin
      if_request = 1'b0;
      if_addr    = '0;
    end
  end

  assign if_valid = !q_empty;
  assign if_pc    = head[ENT_W-1:INST_W];
  assign if_inst  = head[INST_W-1:0];

`ifdef IF_PREFETCH_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (push && (stat_fetch_cnt != '1))    stat_fetch_cnt <= stat_fetch_cnt + 1'b1;
      if (jump_en && (stat_flush_cnt != '1)) stat_flush_cnt <= stat_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: queue-level reference model plus a latency memory.
module tb_if_prefetch;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy_mem_ctrl = 1'b0;
  logic        jump_en = 1'b0;
  logic        id_ready = 1'b0;
  logic [1:0]  if_or_mem_i = 2'b00;
  logic [31:0] mcl_instr = '0;
  logic [31:0] jump_addr = '0;
  logic        if_request;
  logic        if_valid;
  logic [31:0] if_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_PREFETCH_STAT_EN
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_flush_cnt;
`endif

  always #5 clk = ~clk;

  if_prefetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_request    (if_request),
    .if_addr       (if_addr),
    .busy_mem_ctrl (busy_mem_ctrl),
    .if_or_mem_i   (if_or_mem_i),
    .mcl_instr     (mcl_instr),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .id_ready      (id_ready)
`ifdef IF_PREFETCH_STAT_EN
    ,
    .stat_fetch_cnt(stat_fetch_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Reference model: queue contents, next fetch address, outstanding/discard flags.
  ent_t        mq[$];
  logic [31:0] m_fetch_pc = RST_PC;
  bit          m_out = 1'b0;
  bit          m_drop = 1'b0;
  int unsigned m_fetches = 0;
  int unsigned m_flushes = 0;

  bit          mem_pend = 1'b0;
  int unsigned mem_left = 0;
  logic [31:0] mem_data = '0;

  bit          k_rst = 1'b1;
  bit          k_busy = 1'b0;
  bit          k_jump = 1'b0;
  bit          k_ready = 1'b0;
  logic [31:0] k_jaddr = '0;
  int unsigned k_lat = 1;
  int unsigned k_noise = 0;

  bit          e_req;
  bit          e_valid;
  logic [31:0] e_addr;
  logic [31:0] e_pc;
  logic [31:0] e_inst;

  task automatic cycle_begin();
    @(negedge clk);
    rst           = k_rst;
    busy_mem_ctrl = k_busy;
    id_ready      = k_ready;
    jump_addr     = k_jaddr;
    if (mem_pend && mem_left == 0) begin
      if_or_mem_i = 2'b01;
      mcl_instr   = mem_data;
      mem_pend    = 1'b0;
    end else begin
      if_or_mem_i = (k_noise != 0 && $urandom_range(99) < k_noise) ? 2'b10 : 2'b00;
      mcl_instr   = $urandom;
    end
    // A redirect that coincides with a drain response would strand the drain; avoid it.
    jump_en = k_jump && !(m_drop && if_or_mem_i == 2'b01);
    #1;
    e_req   = !k_rst && !m_out && !k_busy && !jump_en && (mq.size() < DEPTH);
    e_addr  = e_req ? m_fetch_pc : 32'h0;
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_inst  = e_valid ? mq[0].inst : 32'h0;
  endtask

  task automatic cycle_end();
    bit resp = (if_or_mem_i == 2'b01);
    if (mem_pend && mem_left > 0) mem_left--;
    if (e_req) begin
      mem_pend = 1'b1;
      mem_left = k_lat - 1;
      mem_data = $urandom;
    end
    if (rst) begin
      mq.delete();
      m_fetch_pc = RST_PC;
      m_out = 1'b0;
      m_drop = 1'b0;
      m_fetches = 0;
      m_flushes = 0;
      mem_pend = 1'b0;
    end else if (jump_en) begin
      mq.delete();
      m_fetch_pc = jump_addr;
      m_flushes++;
      if (m_out && !m_drop) begin
        if (resp) m_out = 1'b0;
        else      m_drop = 1'b1;
      end
    end else begin
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (resp && m_out) begin
        if (!m_drop) begin
          mq.push_back('{pc: m_fetch_pc, inst: mcl_instr});
          m_fetch_pc = m_fetch_pc + 32'd4;
          m_fetches++;
        end
        m_out = 1'b0;
        m_drop = 1'b0;
      end
      if (e_req) m_out = 1'b1;
    end
  endtask

  task automatic do_reset();
    k_rst = 1'b1; k_busy = 1'b0; k_jump = 1'b0; k_ready = 1'b0; k_noise = 0; k_lat = 1;
    repeat (2) begin cycle_begin(); cycle_end(); end
    k_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    k_busy = 1'b1;
    cycle_begin();
    vectors += 5;
    if (if_request !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", if_request); end
    if (if_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", if_addr); end
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    if (if_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp 0", if_pc); end
    if (if_inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst got %h exp 0", if_inst); end
    cycle_end();
    k_busy = 1'b0;
    cycle_begin();
    vectors += 2;
    if (if_request !== 1'b1) begin miscompares++; $display("FAIL reset_first_req got %b exp 1", if_request); end
    if (if_addr !== RST_PC) begin miscompares++; $display("FAIL reset_first_addr got %h exp %h", if_addr, RST_PC); end
    cycle_end();
    // Reset while that fetch is outstanding abandons it.
    k_rst = 1'b1;
    cycle_begin(); cycle_end();
    k_rst = 1'b0; k_busy = 1'b1;
    cycle_begin();
    vectors += 2;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got %b exp 0", if_valid); end
    if (if_request !== 1'b0) begin miscompares++; $display("FAIL midreset_req got %b exp 0", if_request); end
    cycle_end();
    k_busy = 1'b0;
    cycle_begin();
    vectors++;
    if (if_addr !== RST_PC) begin miscompares++; $display("FAIL midreset_addr got %h exp %h", if_addr, RST_PC); end
    cycle_end();
  endtask

  task automatic test_sequential();
    logic [31:0] seen[$];
    do_reset();
    k_ready = 1'b1; k_lat = 1;
    for (int i = 0; i < 14; i++) begin
      cycle_begin();
      vectors += 5;
      if (if_request !== e_req) begin miscompares++; $display("FAIL seq_req got %b exp %b", if_request, e_req); end
      if (if_addr !== e_addr) begin miscompares++; $display("FAIL seq_addr got %h exp %h", if_addr, e_addr); end
      if (if_valid !== e_valid) begin miscompares++; $display("FAIL seq_valid got %b exp %b", if_valid, e_valid); end
      if (if_pc !== e_pc) begin miscompares++; $display("FAIL seq_pc got %h exp %h", if_pc, e_pc); end
      if (if_inst !== e_inst) begin miscompares++; $display("FAIL seq_inst got %h exp %h", if_inst, e_inst); end
      if (if_request === 1'b1) seen.push_back(if_addr);
      cycle_end();
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (seen.size() <= i) begin
        miscompares++; $display("FAIL seq_order req %0d got none exp %h", i, RST_PC + 32'(4 * i));
      end else if (seen[i] !== RST_PC + 32'(4 * i)) begin
        miscompares++; $display("FAIL seq_order req %0d got %h exp %h", i, seen[i], RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_full();
    int unsigned nreq = 0;
    bit          got = 1'b0;
    do_reset();
    k_jump = 1'b1; k_jaddr = 32'h0;
    cycle_begin(); cycle_end();
    k_jump = 1'b0; k_ready = 1'b0; k_lat = 2;
    for (int i = 0; i < 40; i++) begin
      cycle_begin();
      vectors += 2;
      if (if_request !== e_req) begin miscompares++; $display("FAIL full_req got %b exp %b", if_request, e_req); end
      if (if_pc !== e_pc) begin miscompares++; $display("FAIL full_head got %h exp %h", if_pc, e_pc); end
      if (if_request === 1'b1) nreq++;
      cycle_end();
    end
    vectors += 2;
    if (nreq != DEPTH) begin miscompares++; $display("FAIL full_reqcount got %0d exp %0d", nreq, DEPTH); end
    if (if_pc !== 32'h0) begin miscompares++; $display("FAIL full_hold_pc got %h exp 0", if_pc); end
    k_ready = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle_begin();
      if (if_request === 1'b1) begin
        got = 1'b1;
        vectors++;
        if (if_addr !== 32'h10) begin miscompares++; $display("FAIL full_resume got %h exp 10", if_addr); end
      end
      cycle_end();
    end
    if (!got) begin vectors++; miscompares++; $display("FAIL full_resume got timeout exp request"); end
  endtask

  task automatic test_busy();
    int unsigned nreq = 0;
    do_reset();
    k_ready = 1'b0; k_lat = 1;
    repeat (3) begin cycle_begin(); cycle_end(); end
    k_busy = 1'b1; k_noise = 60;
    repeat (5) begin
      cycle_begin();
      vectors += 3;
      if (if_request !== 1'b0) begin miscompares++; $display("FAIL busy_req got %b exp 0", if_request); end
      if (if_valid !== e_valid) begin miscompares++; $display("FAIL busy_valid got %b exp %b", if_valid, e_valid); end
      if (if_inst !== e_inst) begin miscompares++; $display("FAIL busy_inst got %h exp %h", if_inst, e_inst); end
      cycle_end();
    end
    k_busy = 1'b0; k_ready = 1'b1;
    repeat (12) begin
      cycle_begin();
      vectors += 3;
      if (if_request !== e_req) begin miscompares++; $display("FAIL busy_after_req got %b exp %b", if_request, e_req); end
      if (if_addr !== e_addr) begin miscompares++; $display("FAIL busy_after_addr got %h exp %h", if_addr, e_addr); end
      if (if_inst !== e_inst) begin miscompares++; $display("FAIL busy_after_inst got %h exp %h", if_inst, e_inst); end
      if (if_request === 1'b1) nreq++;
      cycle_end();
    end
    vectors++;
    if (nreq == 0) begin miscompares++; $display("FAIL busy_resume got 0 requests exp >0"); end
    k_noise = 0;
  endtask

  task automatic test_redirect_wait();
    bit got = 1'b0;
    do_reset();
    k_ready = 1'b1; k_lat = 3;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle_begin();
      got = (if_request === 1'b1);
      cycle_end();
    end
    k_jump = 1'b1; k_jaddr = 32'h200;
    cycle_begin(); cycle_end();
    k_jump = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle_begin();
      vectors += 2;
      if (if_valid !== e_valid) begin miscompares++; $display("FAIL rdw_valid got %b exp %b", if_valid, e_valid); end
      if (if_request !== e_req) begin miscompares++; $display("FAIL rdw_req got %b exp %b", if_request, e_req); end
      if (if_request === 1'b1) begin
        got = 1'b1;
        vectors++;
        if (if_addr !== 32'h200) begin miscompares++; $display("FAIL rdw_target got %h exp 200", if_addr); end
      end
      cycle_end();
    end
    if (!got) begin vectors++; miscompares++; $display("FAIL rdw_target got timeout exp request"); end
  endtask

  task automatic test_redirect_same_cycle();
    bit got = 1'b0;
    do_reset();
    k_ready = 1'b0; k_lat = 1;
    for (int i = 0; i < 30; i++) begin
      if (mq.size() >= 1 && mem_pend && mem_left == 0) break;
      cycle_begin(); cycle_end();
    end
    k_ready = 1'b1; k_jump = 1'b1; k_jaddr = 32'h300;
    cycle_begin();
    vectors++;
    if (if_valid !== 1'b1) begin miscompares++; $display("FAIL rds_setup_valid got %b exp 1", if_valid); end
    cycle_end();
    k_jump = 1'b0;
    cycle_begin();
    vectors++;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rds_valid got %b exp 0", if_valid); end
    if (if_request === 1'b1) begin
      got = 1'b1;
      vectors++;
      if (if_addr !== 32'h300) begin miscompares++; $display("FAIL rds_target got %h exp 300", if_addr); end
    end
    cycle_end();
    for (int i = 0; i < 10 && !got; i++) begin
      cycle_begin();
      if (if_request === 1'b1) begin
        got = 1'b1;
        vectors++;
        if (if_addr !== 32'h300) begin miscompares++; $display("FAIL rds_target got %h exp 300", if_addr); end
      end
      cycle_end();
    end
    if (!got) begin vectors++; miscompares++; $display("FAIL rds_target got timeout exp request"); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      k_rst   = ($urandom_range(199) == 0);
      k_busy  = ($urandom_range(99) < 20);
      k_jump  = ($urandom_range(99) < 6);
      k_jaddr = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      k_ready = ($urandom_range(99) < 60);
      k_lat   = $urandom_range(3, 1);
      k_noise = 20;
      cycle_begin();
      vectors += 5;
      if (if_request !== e_req) begin miscompares++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, if_request, e_req); end
      if (if_addr !== e_addr) begin miscompares++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, if_addr, e_addr); end
      if (if_valid !== e_valid) begin miscompares++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, if_valid, e_valid); end
      if (if_pc !== e_pc) begin miscompares++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, if_pc, e_pc); end
      if (if_inst !== e_inst) begin miscompares++; $display("FAIL rnd_inst cyc %0d got %h exp %h", i, if_inst, e_inst); end
      cycle_end();
    end
    k_rst = 1'b0; k_jump = 1'b0; k_noise = 0;
  endtask

`ifdef IF_PREFETCH_STAT_EN
  task automatic test_stats();
    do_reset();
    k_ready = 1'b1; k_lat = 1;
    for (int i = 0; i < 30 && m_fetches < 3; i++) begin cycle_begin(); cycle_end(); end
    k_jump = 1'b1; k_jaddr = 32'h400;
    cycle_begin(); cycle_end();
    k_jump = 1'b0; k_busy = 1'b1;
    cycle_begin();
    vectors += 2;
    if (stat_fetch_cnt !== 32'd3) begin miscompares++; $display("FAIL stat_fetch got %0d exp 3", stat_fetch_cnt); end
    if (stat_flush_cnt !== 32'd1) begin miscompares++; $display("FAIL stat_flush got %0d exp 1", stat_flush_cnt); end
    cycle_end();
    k_busy = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_busy();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_random();
`ifdef IF_PREFETCH_STAT_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
